ahb_arbiter: RTL and testbench

- Central bus arbiter that shares one AHB address/data path among up to `AHB_MAX_NUM_MASTERS` master interfaces.
- Decides which requesting master owns the bus:
  - round-robin between requesters;
  - burst-aware, so fixed-length bursts are never broken;
  - lock-aware, so HLOCK sequences are held.
- Drives the HGRANT vector plus the registered HMASTER/HMASTLOCK used by the address/data multiplexers and the slave interfaces.

---
 rtl/ahb_pkg.sv | 47 ++++
 rtl/ahb_rr_picker.sv | 30 +++
 rtl/ahb_arbiter.sv | 151 +++++++++++++++
 tb/tb_ahb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB types and helpers for the bus arbiter and slave-side logic.
package ahb_pkg;

    localparam int unsigned AHB_MAX_NUM_MASTERS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        OKAY  = 2'd0,
        ERROR = 2'd1,
        RETRY = 2'd2,
        SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BURST = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

    // Beat count of a fixed-length burst; SINGLE and INCR report 1.
    function automatic logic [4:0] burst_len(hburst_e b);
        case (b)
            WRAP4,  INCR4:  return 5'd4;
            WRAP8,  INCR8:  return 5'd8;
            WRAP16, INCR16: return 5'd16;
            default:        return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
module ahb_rr_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_c,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);

    logic [IW-1:0] cand_idx;

    always_comb begin
        gnt_c    = '0;
        idx_c    = '0;
        valid_c  = 1'b0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand_idx = IW'((32'(ptr) + i) % N);
            if (!valid_c && req[cand_idx]) begin
                valid_c         = 1'b1;
                idx_c           = cand_idx;
                gnt_c[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant that holds the bus across fixed bursts and locked sequences.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = AHB_MAX_NUM_MASTERS,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

    arb_state_e             state_q, state_d;
    logic [3:0]             remaining_q, remaining_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MW-1:0]          gnt_idx_q, gnt_idx_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;

    logic                   arb_en_c;
    logic                   owner_lock_c;
    htrans_e                trans_c;
    logic [NUM_MASTERS-1:0] pick_gnt_c;
    logic [MW-1:0]          pick_idx_c;
    logic                   pick_valid_c;

    ahb_rr_picker #(
        .N  (NUM_MASTERS),
        .IW (MW)
    ) u_picker (
        .req     (hbusreq),
        .ptr     (rr_ptr_q),
        .gnt_c   (pick_gnt_c),
        .idx_c   (pick_idx_c),
        .valid_c (pick_valid_c)
    );

    // Ownership FSM; arb_en_c opens the grant one beat before a burst ends.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        arb_en_c     = 1'b0;
        trans_c      = htrans_e'(htrans);
        owner_lock_c = hlock[hmaster_q];
        case (state_q)
            ARB: begin
                arb_en_c = 1'b1;
                if (hready && trans_c == NONSEQ) begin
                    if (owner_lock_c) begin
                        state_d = LOCK;
                    end else if (burst_len(hburst_e'(hburst)) > 5'd1) begin
                        state_d     = BURST;
                        remaining_d = 4'(burst_len(hburst_e'(hburst)) - 5'd1);
                    end
                end
            end
            BURST: begin
                if (hready) begin
                    case (trans_c)
                        SEQ: begin
                            remaining_d = remaining_q - 4'd1;
                            arb_en_c    = (remaining_q == 4'd2);
                            if (remaining_q <= 4'd1) begin
                                state_d     = ARB;
                                remaining_d = 4'd0;
                            end
                        end
                        IDLE, NONSEQ: begin
                            state_d     = ARB;
                            remaining_d = 4'd0;
                        end
                        default: ;
                    endcase
                end else if (hresp == 2'(ERROR)) begin
                    state_d     = ARB;
                    remaining_d = 4'd0;
                end
            end
            LOCK: begin
                if (!owner_lock_c) begin
                    arb_en_c = 1'b1;
                    if (hready) begin
                        state_d = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Grant and address-phase owner; hmaster trails hgrant by one accepted cycle.
    always_comb begin
        hgrant_d    = hgrant_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (hready) begin
            hmaster_d   = gnt_idx_q;
            hmastlock_d = hlock[gnt_idx_q];
            if (arb_en_c) begin
                if (pick_valid_c) begin
                    hgrant_d  = pick_gnt_c;
                    gnt_idx_d = pick_idx_c;
                    rr_ptr_d  = pick_idx_c;
                end else begin
                    hgrant_d  = DEF_GNT;
                    gnt_idx_d = DEF_IDX;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ARB;
            remaining_q <= 4'd0;
            hgrant_q    <= DEF_GNT;
            gnt_idx_q   <= DEF_IDX;
            rr_ptr_q    <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            hgrant_q    <= hgrant_d;
            gnt_idx_q   <= gnt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: round-robin, burst hold, wait states, lock and error exit.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned MW = 2;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic [N-1:0]  hbusreq;
    logic [N-1:0]  hlock;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hready;
    logic [1:0]    hresp;
    logic [N-1:0]  hgrant;
    logic [MW-1:0] hmaster;
    logic          hmastlock;

    int checks = 0;
    int errors = 0;

    ahb_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (0),
        .MW             (MW)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        hbusreq = '0;
        hlock   = '0;
        htrans  = 2'(IDLE);
        hburst  = 3'(SINGLE);
        hready  = 1'b1;
        hresp   = 2'(OKAY);
        step();
        step();
        hresetn = 1'b1;
    endtask

    // Grant M<m> from reset and let hmaster catch up: two accepted edges.
    task automatic grant_owner(input logic [N-1:0] req);
        hbusreq = req;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (hgrant !== 4'b0001) begin
            errors++; $display("FAIL reset_hgrant: got %b want 0001", hgrant);
        end
        checks++;
        if (hmaster !== 2'd0) begin
            errors++; $display("FAIL reset_hmaster: got %0d want 0", hmaster);
        end
        checks++;
        if (hmastlock !== 1'b0) begin
            errors++; $display("FAIL reset_hmastlock: got %b want 0", hmastlock);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        grant_owner(4'b0010);
        htrans = 2'(NONSEQ); hburst = 3'(INCR8);
        step();
        htrans = 2'(SEQ);
        step();
        hresetn = 1'b0;
        #2;
        checks++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst: got grant=%b master=%0d lock=%b want 0001/0/0",
                     hgrant, hmaster, hmastlock);
        end
        hresetn = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  exp_g [3];
        logic [MW-1:0] exp_m [3];
        exp_g[0] = 4'b0010; exp_m[0] = 2'd0;
        exp_g[1] = 4'b0100; exp_m[1] = 2'd1;
        exp_g[2] = 4'b0010; exp_m[2] = 2'd2;
        do_reset();
        hbusreq = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (hgrant !== exp_g[i]) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, hgrant, exp_g[i]);
            end
            checks++;
            if (hmaster !== exp_m[i]) begin
                errors++; $display("FAIL rr_master[%0d]: got %0d want %0d", i, hmaster, exp_m[i]);
            end
        end
    endtask

    task automatic test_burst_hold();
        do_reset();
        grant_owner(4'b0010);
        htrans = 2'(NONSEQ); hburst = 3'(INCR8);
        step();
        htrans = 2'(SEQ);
        hbusreq = 4'b0110;
        for (int beat = 2; beat <= 8; beat++) begin
            step();
            checks++;
            if (beat <= 6 && (hgrant !== 4'b0010 || hmaster !== 2'd1)) begin
                errors++;
                $display("FAIL burst_hold beat%0d: got grant=%b master=%0d want 0010/1",
                         beat, hgrant, hmaster);
            end else if (beat == 7 && (hgrant !== 4'b0100 || hmaster !== 2'd1)) begin
                errors++;
                $display("FAIL burst_handover beat7: got grant=%b master=%0d want 0100/1",
                         hgrant, hmaster);
            end else if (beat == 8 && (hgrant !== 4'b0100 || hmaster !== 2'd2)) begin
                errors++;
                $display("FAIL burst_end beat8: got grant=%b master=%0d want 0100/2",
                         hgrant, hmaster);
            end
        end
        htrans = 2'(IDLE);
    endtask

    task automatic test_wait_states();
        do_reset();
        grant_owner(4'b0010);
        htrans = 2'(NONSEQ); hburst = 3'(INCR4);
        step();
        htrans = 2'(SEQ);
        hbusreq = 4'b0110;
        hready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            step();
            checks++;
            if (hgrant !== 4'b0010 || hmaster !== 2'd1) begin
                errors++;
                $display("FAIL wait_frozen[%0d]: got grant=%b master=%0d want 0010/1",
                         w, hgrant, hmaster);
            end
        end
        hready = 1'b1;
        step();
        checks++;
        if (hgrant !== 4'b0010) begin
            errors++; $display("FAIL wait_beat2: got grant=%b want 0010", hgrant);
        end
        step();
        checks++;
        if (hgrant !== 4'b0100 || hmaster !== 2'd1) begin
            errors++;
            $display("FAIL wait_beat3: got grant=%b master=%0d want 0100/1", hgrant, hmaster);
        end
        step();
        checks++;
        if (hmaster !== 2'd2) begin
            errors++; $display("FAIL wait_beat4: got master=%0d want 2", hmaster);
        end
        htrans = 2'(IDLE);
    endtask

    task automatic test_lock();
        do_reset();
        hlock = 4'b1000;
        grant_owner(4'b1000);
        checks++;
        if (hmaster !== 2'd3 || hmastlock !== 1'b1) begin
            errors++;
            $display("FAIL lock_entry: got master=%0d lock=%b want 3/1", hmaster, hmastlock);
        end
        htrans = 2'(NONSEQ); hburst = 3'(INCR4);
        step();
        hbusreq = 4'b1001;
        for (int b = 0; b < 7; b++) begin
            htrans = (b == 3) ? 2'(NONSEQ) : 2'(SEQ);
            step();
            checks++;
            if (hgrant !== 4'b1000 || hmaster !== 2'd3 || hmastlock !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got grant=%b master=%0d lock=%b want 1000/3/1",
                         b, hgrant, hmaster, hmastlock);
            end
        end
        hlock = 4'b0000;
        htrans = 2'(IDLE);
        step();
        checks++;
        if (hgrant !== 4'b0001 || hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: got grant=%b lock=%b want 0001/0", hgrant, hmastlock);
        end
        step();
        checks++;
        if (hmaster !== 2'd0) begin
            errors++; $display("FAIL lock_release_master: got %0d want 0", hmaster);
        end
    endtask

    task automatic test_error_exit();
        do_reset();
        grant_owner(4'b0100);
        htrans = 2'(NONSEQ); hburst = 3'(WRAP16);
        step();
        hbusreq = 4'b0101;
        htrans = 2'(SEQ);
        for (int b = 2; b <= 4; b++) step();
        hready = 1'b0;
        hresp  = 2'(ERROR);
        step();
        checks++;
        if (hgrant !== 4'b0100 || hmaster !== 2'd2) begin
            errors++;
            $display("FAIL error_first: got grant=%b master=%0d want 0100/2", hgrant, hmaster);
        end
        hready = 1'b1;
        htrans = 2'(IDLE);
        step();
        hresp = 2'(OKAY);
        checks++;
        if (hgrant !== 4'b0001) begin
            errors++; $display("FAIL error_regrant: got grant=%b want 0001", hgrant);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_hold();
        test_wait_states();
        test_lock();
        test_error_exit();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
